event_blinker: RTL and testbench

//  Output-side counterpart of the push-button debouncer. Turns 1-clock event pulses
//  (e.g. debounced button strobes, FFT-done strobes) into human-visible LED blinks.

---
 rtl/event_blinker_if.sv | 33 +++
 rtl/event_blinker.sv | 138 +++++++++++++
 tb/tb_event_blinker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/event_blinker_if.sv
// Event/LED bundle between an event source and the event_blinker.
// The master side issues event strobes and flushes; the slave side
// (the blinker) drives the LED and status signals.
interface event_blinker_if #(
  parameter int MAX_PEND = 15
) ();
  localparam int PW = $clog2(MAX_PEND + 1);

  logic          pulse_in;
  logic          clear;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse_in,
    output clear,
    input  led,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    input  clear,
    output led,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/event_blinker.sv
// event_blinker: turns 1-clock event strobes into visible LED blinks.
// Each accepted event produces one blink: T_ON cycles on, then at least
// T_OFF cycles off. Events arriving mid-blink wait in a saturating
// counter of depth MAX_PEND.
// Optional feature: define EVENT_BLINKER_OVERFLOW_EN to implement the
// sticky overflow flag; otherwise overflow is tied low and drops are silent.
module event_blinker #(
  parameter int T_ON     = 2_000_000,
  parameter int T_OFF    = 2_000_000,
  parameter int MAX_PEND = 15
) (
  input  logic          clk,
  input  logic          nReset,
  event_blinker_if.slave bus
);
  localparam int PW   = $clog2(MAX_PEND + 1);
  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [PW-1:0] r_pending;
  logic [PW-1:0] w_pending_nxt;
  logic          r_led;
  logic          w_consume;
  logic          w_can_start;

  // A flush in the same cycle hides the queue, so no new blink may start.
  assign w_can_start = (r_pending != '0) && !bus.clear;

  // Next-state logic: sequence ON/GAP phases and decide when to consume.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_state_nxt = S_ON;
          w_timer_nxt = TW'(T_ON - 1);
          w_consume   = 1'b1;
        end
      end
      S_ON: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          w_state_nxt = S_GAP;
          w_timer_nxt = TW'(T_OFF - 1);
        end
      end
      S_GAP: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TW'(1);
        end else if (w_can_start) begin
          w_state_nxt = S_ON;
          w_timer_nxt = TW'(T_ON - 1);
          w_consume   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Pending-count update: +1 per event, -1 per consume, saturate at MAX_PEND.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.clear) begin
      w_pending_nxt = '0;
    end else if (bus.pulse_in && !w_consume) begin
      if (r_pending != PW'(MAX_PEND)) begin
        w_pending_nxt = r_pending + PW'(1);
      end
    end else if (!bus.pulse_in && w_consume) begin
      w_pending_nxt = r_pending - PW'(1);
    end
  end

  // State register with synchronous active-low reset; led registered from next state.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!nReset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_pending <= '0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_pending <= w_pending_nxt;
      r_led     <= (w_state_nxt == S_ON);
    end
  end

`ifdef EVENT_BLINKER_OVERFLOW_EN
  logic r_overflow;
  logic w_drop;

  // An event is lost only when the queue is full and nothing is consumed.
  assign w_drop = bus.pulse_in && !bus.clear && !w_consume &&
                  (r_pending == PW'(MAX_PEND));

  // Sticky overflow flag, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.led     = r_led;
  assign bus.busy    = (r_state != S_IDLE) || (r_pending != '0);
  assign bus.pending = r_pending;
endmodule

// File: tb/tb_event_blinker.sv
// Self-checking bench for event_blinker (T_ON=4, T_OFF=3, MAX_PEND=3).
// A blink-schedule reference model predicts the outputs after each edge
// and queues them; a negedge monitor pops and compares.
module tb_event_blinker;
  localparam int T_ON     = 4;
  localparam int T_OFF    = 3;
  localparam int MAX_PEND = 3;
  localparam int PERIOD   = T_ON + T_OFF;
`ifdef EVENT_BLINKER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    bit led;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic nReset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: a blink is "active" with a phase counting cycles
  // since it started; LED is on for the first T_ON phases.
  bit m_active = 1'b0;
  int m_phase  = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;

  event_blinker_if #(.MAX_PEND(MAX_PEND)) bus ();

  event_blinker #(
    .T_ON    (T_ON),
    .T_OFF   (T_OFF),
    .MAX_PEND(MAX_PEND)
  ) u_dut (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit p, input bit c, input bit r);
    bit   start_ok;
    bit   consume;
    int   np;
    exp_t e;
    if (!r) begin
      m_active = 1'b0;
      m_phase  = 0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else begin
      start_ok = (m_pend > 0) && !c;
      consume  = 1'b0;
      if (m_active) begin
        if (m_phase == PERIOD - 1) begin
          if (start_ok) begin
            m_phase = 0;
            consume = 1'b1;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_phase++;
        end
      end else if (start_ok) begin
        m_active = 1'b1;
        m_phase  = 0;
        consume  = 1'b1;
      end
      if (c) begin
        m_pend = 0;
        m_ovf  = 1'b0;
      end else begin
        np = m_pend + int'(p) - int'(consume);
        if (np > MAX_PEND) begin
          np = MAX_PEND;
          if (OVF_EN) m_ovf = 1'b1;
        end
        m_pend = np;
      end
    end
    e.led  = m_active && (m_phase < T_ON);
    e.busy = m_active || (m_pend > 0);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, record the expectation, then cross the edge.
  task automatic step(input bit p, input bit c, input bit r);
    bus.pulse_in = p;
    bus.clear    = c;
    nReset       = r;
    model_edge(p, c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led",      int'(bus.led),      int'(e.led));
      check("busy",     int'(bus.busy),     int'(e.busy));
      check("pending",  int'(bus.pending),  e.pend);
      check("overflow", int'(bus.overflow), int'(e.ovf));
    end
  end

  initial begin
    int prob;
    bus.pulse_in = 1'b0;
    bus.clear    = 1'b0;
    nReset       = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Single event: one 4-on / 3-off blink
    step(1'b1, 1'b0, 1'b1);
    idle(12);

    // Three back-to-back events: three blinks
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    idle(25);

    // Five events: queue saturates, fifth is dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    check("s3_pending_sat", int'(bus.pending), MAX_PEND);
    check("s3_overflow", int'(bus.overflow), int'(OVF_EN));
    idle(35);

    // Clear during the first ON: that blink completes, nothing after
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("s4_pending_clr", int'(bus.pending), 0);
    check("s4_overflow_clr", int'(bus.overflow), 0);
    idle(15);

    // Reset mid-blink with events queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b0);
    check("s5_led_rst", int'(bus.led), 0);
    check("s5_busy_rst", int'(bus.busy), 0);
    idle(15);

    // Event coinciding with the GAP->ON consume edge
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(6);
    step(1'b1, 1'b0, 1'b1);
    idle(25);

    // Randomized traffic with bursty event density, rare clears and resets
    prob = 20;
    for (int i = 0; i < 2000; i++) begin
      if (i % 40 == 0) prob = $urandom_range(90, 0);
      step($urandom_range(99, 0) < prob,
           $urandom_range(99, 0) < 2,
           $urandom_range(299, 0) != 0);
    end
    idle(20);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
